adc_spi_reader: RTL

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_pkg.sv | 31 +++
 rtl/adc_sclk_gen.sv | 37 +++
 rtl/adc_spi_reader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and MCP3202 framing constants for the ADC SPI reader.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        WAIT
    } state_t;

    localparam int         ADC_BITS    = 12;
    localparam logic [4:0] FRAME_SCLKS = 5'd17;
    localparam logic [4:0] NULL_SCLK   = 5'd5;

    localparam logic CMD_START = 1'b1;
    localparam logic CMD_SGL   = 1'b1;
    localparam logic CMD_MSBF  = 1'b1;

    // DIN value driven during SCLK period idx (1-based); zero after the command.
    function automatic logic cmd_bit(input logic [4:0] idx, input logic odd);
        case (idx)
            5'd1:    return CMD_START;
            5'd2:    return CMD_SGL;
            5'd3:    return odd;
            5'd4:    return CMD_MSBF;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK half-period timer: tick marks the last clk of each half-period,
// rise/fall flag the clk on which adc_sclk toggles.
module adc_sclk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sclk_en,
    output logic sclk,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));
    assign rise = sclk_en && tick && !sclk;
    assign fall = sclk_en && tick && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            if (!en || tick) cnt <= '0;
            else             cnt <= cnt + 1'b1;

            if (!sclk_en)  sclk <= 1'b0;
            else if (tick) sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// Periodic MCP3202 single-ended conversion reader (SPI mode 0,0).
// Frame: CS setup, 17 SCLK periods, CS hold; result published on CS release.
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int CHANNEL       = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic                adc_mosi,
    input  logic                adc_miso,
    output logic [ADC_BITS-1:0] adc_data,
    output logic                data_valid,
    output logic                busy
);

    localparam int   TW  = $clog2(SAMPLE_PERIOD + 1);
    localparam int   WW  = $clog2(2 * CLK_DIV);
    localparam logic ODD = (CHANNEL != 0);

    state_t              state, state_nxt;
    logic [4:0]          bit_idx;
    logic [WW-1:0]       wait_cnt;
    logic [TW-1:0]       timer;
    logic [ADC_BITS-1:0] shreg;

    logic tick, rise, fall;
    logic gen_en, sclk_en;
    logic cs_n_nxt, mosi_nxt;
    logic start, load, shift_in, idx_load, idx_inc;
    logic timer_exp, wait_done;

    // Count-down timer: zero means a new frame may start, so reset leaves it expired.
    assign timer_exp = (timer == '0);
    // WAIT plus the single IDLE cycle give exactly 2*CLK_DIV clks of CS high.
    assign wait_done = (wait_cnt == WW'(2 * CLK_DIV - 2));
    assign busy      = ~adc_cs_n;

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (gen_en),
        .sclk_en (sclk_en),
        .sclk    (adc_sclk),
        .tick    (tick),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (timer_exp)                       state_nxt = CS_SETUP;
            CS_SETUP: if (tick)                            state_nxt = SHIFT;
            SHIFT:    if (fall && bit_idx == FRAME_SCLKS)  state_nxt = CS_HOLD;
            CS_HOLD:  if (tick)                            state_nxt = WAIT;
            WAIT:     if (wait_done)                       state_nxt = IDLE;
            default:                                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gen_en   = (state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD);
        sclk_en  = (state == SHIFT);
        cs_n_nxt = adc_cs_n;
        mosi_nxt = adc_mosi;
        start    = 1'b0;
        load     = 1'b0;
        shift_in = 1'b0;
        idx_load = 1'b0;
        idx_inc  = 1'b0;
        case (state)
            IDLE: if (timer_exp) begin
                start    = 1'b1;
                cs_n_nxt = 1'b0;
                mosi_nxt = CMD_START;
            end
            CS_SETUP: if (tick) begin
                idx_load = 1'b1;
                mosi_nxt = cmd_bit(5'd1, ODD);
            end
            SHIFT: begin
                shift_in = rise && (bit_idx > NULL_SCLK);
                if (fall) begin
                    idx_inc  = 1'b1;
                    mosi_nxt = cmd_bit(bit_idx + 5'd1, ODD);
                end
            end
            CS_HOLD: if (tick) begin
                cs_n_nxt = 1'b1;
                load     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_cs_n   <= 1'b1;
            adc_mosi   <= 1'b0;
            adc_data   <= '0;
            data_valid <= 1'b0;
            shreg      <= '0;
            timer      <= '0;
            wait_cnt   <= '0;
            bit_idx    <= '0;
        end else begin
            adc_cs_n   <= cs_n_nxt;
            adc_mosi   <= mosi_nxt;
            data_valid <= load;
            if (load)     adc_data <= shreg;
            if (shift_in) shreg    <= {shreg[ADC_BITS-2:0], adc_miso};

            if (start)               timer <= TW'(SAMPLE_PERIOD - 1);
            else if (!timer_exp)     timer <= timer - 1'b1;

            if (state != WAIT) wait_cnt <= '0;
            else               wait_cnt <= wait_cnt + 1'b1;

            if (idx_load)     bit_idx <= 5'd1;
            else if (idx_inc) bit_idx <= bit_idx + 5'd1;
        end
    end

endmodule
